// File: rtl/sid_pkg.sv
// sid_pkg: register map, voice stride and bus-value lifetimes shared by the SID register file
package sid_pkg;

    localparam int TTL_W = 20;

    localparam int DECAY_6581_DEF = 7424;
    localparam int DECAY_8580_DEF = 663552;

    localparam logic [4:0] VOICE_STRIDE = 5'd7;

    localparam logic [4:0] REG_FREQ_LO  = 5'h00;
    localparam logic [4:0] REG_FREQ_HI  = 5'h01;
    localparam logic [4:0] REG_PW_LO    = 5'h02;
    localparam logic [4:0] REG_PW_HI    = 5'h03;
    localparam logic [4:0] REG_CONTROL  = 5'h04;
    localparam logic [4:0] REG_AD       = 5'h05;
    localparam logic [4:0] REG_SR       = 5'h06;
    localparam logic [4:0] REG_FC_LO    = 5'h15;
    localparam logic [4:0] REG_FC_HI    = 5'h16;
    localparam logic [4:0] REG_RES_FILT = 5'h17;
    localparam logic [4:0] REG_MODE_VOL = 5'h18;
    localparam logic [4:0] REG_POTX     = 5'h19;
    localparam logic [4:0] REG_POTY     = 5'h1A;
    localparam logic [4:0] REG_OSC3     = 5'h1B;
    localparam logic [4:0] REG_ENV3     = 5'h1C;

endpackage

// File: rtl/sid_voice_regs.sv
// sid_voice_regs: the seven write-only registers of one SID voice at address BASE
module sid_voice_regs
    import sid_pkg::*;
#(
    parameter logic [4:0] BASE = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [4:0]  addr,
    input  logic [7:0]  data_in,
    output logic [15:0] freq,
    output logic [11:0] pw,
    output logic [7:0]  control,
    output logic [7:0]  att_dec,
    output logic [7:0]  sus_rel
);

    logic [15:0] freq_q, freq_d;
    logic [11:0] pw_q, pw_d;
    logic [7:0]  control_q, control_d, att_dec_q, att_dec_d, sus_rel_q, sus_rel_d;
    logic [4:0]  off;
    logic        hit;

    // addresses below BASE wrap to large offsets, so one compare bounds both ends
    assign off = addr - BASE;
    assign hit = wr && (off < VOICE_STRIDE);

    always_comb begin
        freq_d[7:0]  = (hit && off == REG_FREQ_LO) ? data_in      : freq_q[7:0];
        freq_d[15:8] = (hit && off == REG_FREQ_HI) ? data_in      : freq_q[15:8];
        pw_d[7:0]    = (hit && off == REG_PW_LO)   ? data_in      : pw_q[7:0];
        pw_d[11:8]   = (hit && off == REG_PW_HI)   ? data_in[3:0] : pw_q[11:8];
        control_d    = (hit && off == REG_CONTROL) ? data_in      : control_q;
        att_dec_d    = (hit && off == REG_AD)      ? data_in      : att_dec_q;
        sus_rel_d    = (hit && off == REG_SR)      ? data_in      : sus_rel_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            freq_q    <= '0;
            pw_q      <= '0;
            control_q <= '0;
            att_dec_q <= '0;
            sus_rel_q <= '0;
        end else begin
            freq_q    <= freq_d;
            pw_q      <= pw_d;
            control_q <= control_d;
            att_dec_q <= att_dec_d;
            sus_rel_q <= sus_rel_d;
        end
    end

    assign freq    = freq_q;
    assign pw      = pw_q;
    assign control = control_q;
    assign att_dec = att_dec_q;
    assign sus_rel = sus_rel_q;

endmodule

// File: rtl/sid_regs.sv
// sid_regs: SID CPU register file with registered read port and a decaying data-bus value
module sid_regs
    import sid_pkg::*;
#(
    parameter int DECAY_6581 = DECAY_6581_DEF,
    parameter int DECAY_8580 = DECAY_8580_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_1m,
    input  logic             mode,
    input  logic             cs,
    input  logic             we,
    input  logic [4:0]       addr,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    input  logic [7:0]       pot_x,
    input  logic [7:0]       pot_y,
    input  logic [7:0]       osc3,
    input  logic [7:0]       env3,
    output logic [2:0][15:0] freq,
    output logic [2:0][11:0] pw,
    output logic [2:0][7:0]  control,
    output logic [2:0][7:0]  att_dec,
    output logic [2:0][7:0]  sus_rel,
    output logic [10:0]      fc,
    output logic [7:0]       Res_Filt,
    output logic [7:0]       Mode_Vol
);

    logic             wr, rd;
    logic [7:0]       data_out_q, data_out_d, bus_value_q, bus_value_d;
    logic [7:0]       res_filt_q, res_filt_d, mode_vol_q, mode_vol_d;
    logic [10:0]      fc_q, fc_d;
    logic [TTL_W-1:0] ttl_q, ttl_d;

    assign wr = cs && we && ce_1m;
    assign rd = cs && !we && ce_1m;

    for (genvar g = 0; g < 3; g++) begin : g_voice
        sid_voice_regs #(
            .BASE(5'(g) * VOICE_STRIDE)
        ) u_voice (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr),
            .addr    (addr),
            .data_in (data_in),
            .freq    (freq[g]),
            .pw      (pw[g]),
            .control (control[g]),
            .att_dec (att_dec[g]),
            .sus_rel (sus_rel[g])
        );
    end

    always_comb begin
        fc_d[2:0]   = (wr && addr == REG_FC_LO)    ? data_in[2:0] : fc_q[2:0];
        fc_d[10:3]  = (wr && addr == REG_FC_HI)    ? data_in      : fc_q[10:3];
        res_filt_d  = (wr && addr == REG_RES_FILT) ? data_in      : res_filt_q;
        mode_vol_d  = (wr && addr == REG_MODE_VOL) ? data_in      : mode_vol_q;
        // the lifetime is latched at write time, so a later mode change leaves a running ttl alone
        ttl_d       = wr ? (mode ? TTL_W'(DECAY_8580) : TTL_W'(DECAY_6581))
                    : (ce_1m && ttl_q != '0) ? ttl_q - TTL_W'(1) : ttl_q;
        bus_value_d = wr ? data_in : (ce_1m && ttl_q == TTL_W'(1)) ? 8'h00 : bus_value_q;
        data_out_d  = !rd                ? data_out_q
                    : addr == REG_POTX   ? pot_x
                    : addr == REG_POTY   ? pot_y
                    : addr == REG_OSC3   ? osc3
                    : addr == REG_ENV3   ? env3
                    :                      bus_value_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fc_q        <= '0;
            res_filt_q  <= '0;
            mode_vol_q  <= '0;
            ttl_q       <= '0;
            bus_value_q <= '0;
            data_out_q  <= '0;
        end else begin
            fc_q        <= fc_d;
            res_filt_q  <= res_filt_d;
            mode_vol_q  <= mode_vol_d;
            ttl_q       <= ttl_d;
            bus_value_q <= bus_value_d;
            data_out_q  <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign fc       = fc_q;
    assign Res_Filt = res_filt_q;
    assign Mode_Vol = mode_vol_q;

endmodule

// File: tb/tb_sid_regs.sv
// tb_sid_regs: scoreboard bench comparing sid_regs against a byte-array and bus-age reference model
module tb_sid_regs;

    // the 8580 lifetime is shortened so its expiry fits in a short run; 6581 keeps its real value
    localparam int D6581 = 7424;
    localparam int D8580 = 12000;

    logic             clk = 1'b0;
    logic             reset = 1'b0, ce_1m = 1'b0, mode = 1'b0, cs = 1'b0, we = 1'b0;
    logic [4:0]       addr = '0;
    logic [7:0]       data_in = '0, data_out;
    logic [7:0]       pot_x = '0, pot_y = '0, osc3 = '0, env3 = '0;
    logic [2:0][15:0] freq;
    logic [2:0][11:0] pw;
    logic [2:0][7:0]  control, att_dec, sus_rel;
    logic [10:0]      fc;
    logic [7:0]       Res_Filt, Mode_Vol;

    sid_regs #(.DECAY_6581(D6581), .DECAY_8580(D8580)) dut (
        .clk(clk), .reset(reset), .ce_1m(ce_1m), .mode(mode), .cs(cs), .we(we),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .pot_x(pot_x), .pot_y(pot_y), .osc3(osc3), .env3(env3),
        .freq(freq), .pw(pw), .control(control), .att_dec(att_dec), .sus_rel(sus_rel),
        .fc(fc), .Res_Filt(Res_Filt), .Mode_Vol(Mode_Vol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   d;
        logic [182:0] r;
        int           n;
    } exp_t;

    exp_t sb[$];
    int compared = 0, mismatched = 0, txn = 0;

    // reference model: register bytes by address, plus the last written bus byte and its age in ticks
    logic [7:0] m [0:24];
    logic [7:0] m_bus = '0, m_dout = '0;
    int m_age = 0, m_life = 0;
    logic [7:0] px_n = '0, py_n = '0, osc_n = '0, env_n = '0;
    logic mode_n = 1'b0;

    function automatic logic [182:0] image();
        logic [2:0][15:0] f;
        logic [2:0][11:0] p;
        logic [2:0][7:0] c, a, s;
        logic [7:0] fl;
        for (int v = 0; v < 3; v++) begin
            f[v] = {m[7*v+1], m[7*v]};
            p[v] = {m[7*v+3][3:0], m[7*v+2]};
            c[v] = m[7*v+4];
            a[v] = m[7*v+5];
            s[v] = m[7*v+6];
        end
        fl = m[21];
        return {f, p, c, a, s, m[22], fl[2:0], m[23], m[24]};
    endfunction

    task automatic cyc(input bit r, input bit c, input bit w, input bit e,
                       input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        reset = r; cs = c; we = w; ce_1m = e; addr = a; data_in = d;
        pot_x = px_n; pot_y = py_n; osc3 = osc_n; env3 = env_n; mode = mode_n;
        if (r) begin
            for (int i = 0; i < 25; i++) m[i] = '0;
            m_bus = '0; m_dout = '0; m_age = 0; m_life = 0;
        end else if (e) begin
            if (c && !w)
                m_dout = a == 5'h19 ? px_n : a == 5'h1A ? py_n : a == 5'h1B ? osc_n :
                         a == 5'h1C ? env_n : (m_age < m_life ? m_bus : 8'h00);
            if (c && w) begin
                if (a < 25)
                    m[a] = d & (a == 21 ? 8'h07 : (a < 21 && a % 7 == 3) ? 8'h0F : 8'hFF);
                m_bus = d;
                m_life = mode_n ? D8580 : D6581;
                m_age = 0;
            end else m_age++;
        end
        if (r || (c && e)) begin
            sb.push_back('{m_dout, image(), txn});
            txn++;
        end
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
        cyc(0, 1, 1, 1, a, d);
    endtask

    task automatic rd_reg(input logic [4:0] a);
        cyc(0, 1, 0, 1, a, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 5'h00, 8'h00);
    endtask

    always @(posedge clk) begin
        logic resp;
        exp_t ex;
        logic [182:0] got;
        resp = reset || (cs && ce_1m);
        #1;
        if (resp) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_response at %0t: DUT responded with no expectation queued", $time);
            end else begin
                ex = sb.pop_front();
                got = {freq, pw, control, att_dec, sus_rel, fc, Res_Filt, Mode_Vol};
                if (data_out !== ex.d) begin
                    mismatched++;
                    $display("FAIL data_out#%0d got %02h expected %02h", ex.n, data_out, ex.d);
                end
                compared++;
                if (got !== ex.r) begin
                    mismatched++;
                    $display("FAIL regs#%0d got %046h expected %046h", ex.n, got, ex.r);
                end
            end
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 5'h00, 8'h00);
        cyc(1, 0, 0, 1, 5'h00, 8'h00);
        // voice 0 frequency, then pulse-width and cutoff masking with bus readback
        wr_reg(5'h00, 8'h34);
        wr_reg(5'h01, 8'h12);
        wr_reg(5'h03, 8'hFF);
        wr_reg(5'h15, 8'hFF);
        rd_reg(5'h03);
        osc_n = 8'h5C; env_n = 8'hC3; px_n = 8'h11; py_n = 8'h22;
        rd_reg(5'h1B);
        rd_reg(5'h1C);
        rd_reg(5'h19);
        rd_reg(5'h1A);
        rd_reg(5'h1D);
        // writes without ce_1m must be ignored
        cyc(0, 1, 1, 0, 5'h07, 8'h99);
        rd_reg(5'h07);
        // 6581 expiry boundary
        mode_n = 1'b0;
        wr_reg(5'h18, 8'hAA);
        idle(7423);
        rd_reg(5'h1D);
        rd_reg(5'h1D);
        // 8580 lifetime outlasts the 6581 one
        mode_n = 1'b1;
        wr_reg(5'h18, 8'hAA);
        idle(7423);
        rd_reg(5'h1D);
        idle(D8580 - 1 - 7425);
        rd_reg(5'h1D);
        rd_reg(5'h1D);
        // mode change during decay keeps the old lifetime
        mode_n = 1'b0;
        wr_reg(5'h1E, 8'h3C);
        mode_n = 1'b1;
        idle(7423);
        rd_reg(5'h1F);
        rd_reg(5'h1F);
        // write on the expiry tick wins
        mode_n = 1'b0;
        wr_reg(5'h1F, 8'h77);
        idle(7423);
        wr_reg(5'h1F, 8'h66);
        rd_reg(5'h1D);
        // reset mid-decay with a coincident write
        wr_reg(5'h18, 8'h0F);
        idle(100);
        cyc(1, 1, 1, 1, 5'h18, 8'h55);
        rd_reg(5'h1F);
        for (int i = 0; i < 3000; i++) begin
            px_n = 8'($urandom); py_n = 8'($urandom); osc_n = 8'($urandom); env_n = 8'($urandom);
            if ($urandom_range(0, 49) == 0) mode_n = ~mode_n;
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 3) != 0, 5'($urandom), 8'($urandom));
        end
        cyc(0, 0, 0, 0, 5'h00, 8'h00);
        cyc(0, 0, 0, 0, 5'h00, 8'h00);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sid_regs.md
SID_REGS -- requirements
Module: sid_regs

Interface
Parameters
REQ-001 The block SHALL have parameter DECAY_6581, default 7424, meaning the bus-value lifetime in ce_1m ticks when mode=0.
REQ-002 The block SHALL have parameter DECAY_8580, default 663552, meaning the bus-value lifetime in ce_1m ticks when mode=1.

Ports
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, the only clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ce_1m, input, 1 bit: one-clk-wide SID tick enable (~1 MHz).
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = MOS6581, 1 = MOS8580.
REQ-007 The block SHALL have port cs, input, 1 bit: chip select.
REQ-008 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port addr, input, 5 bits: register address.
REQ-010 The block SHALL have port data_in, input, 8 bits: CPU write data.
REQ-011 The block SHALL have port data_out, output, 8 bits: CPU read data.
REQ-012 The block SHALL have port pot_x, input, 8 bits: paddle X value.
REQ-013 The block SHALL have port pot_y, input, 8 bits: paddle Y value.
REQ-014 The block SHALL have port osc3, input, 8 bits: voice-3 oscillator MSBs.
REQ-015 The block SHALL have port env3, input, 8 bits: voice-3 envelope.
REQ-016 The block SHALL have port freq, output, 3x16 bits: per-voice frequency.
REQ-017 The block SHALL have port pw, output, 3x12 bits: per-voice pulse width.
REQ-018 The block SHALL have port control, output, 3x8 bits: per-voice control register.
REQ-019 The block SHALL have port att_dec, output, 3x8 bits: per-voice attack/decay.
REQ-020 The block SHALL have port sus_rel, output, 3x8 bits: per-voice sustain/release.
REQ-021 The block SHALL have port fc, output, 11 bits: filter cutoff {FC_HI, FC_LO[2:0]}.
REQ-022 The block SHALL have port Res_Filt, output, 8 bits: resonance/filter routing, consumed by the filter.
REQ-023 The block SHALL have port Mode_Vol, output, 8 bits: filter mode/volume, consumed by the filter.

Function
REQ-024 Write decode: voice v (v = 0..2) SHALL occupy base 7v: +0 FREQ_LO, +1 FREQ_HI, +2 PW_LO, +3 PW_HI (bits 3:0 only), +4 CONTROL, +5 AD, +6 SR.
REQ-025 Addresses 0x15 FC_LO (bits 2:0 only), 0x16 FC_HI, 0x17 RES_FILT and 0x18 MODE_VOL SHALL be writable.
REQ-026 Writes to 0x19-0x1F SHALL change no register but SHALL still update the bus value (REQ-029).
REQ-027 A write SHALL occur on a clk edge where cs && we && ce_1m; the target output SHALL show the new value on the next edge (1-cycle latency).
REQ-028 Reads SHALL be registered: on a clk edge where cs && !we && ce_1m, data_out SHALL load 0x19 pot_x, 0x1A pot_y, 0x1B osc3, 0x1C env3, and bus_value for every other address; data_out SHALL otherwise hold.
REQ-029 Bus value: every write SHALL load bus_value = data_in and ttl = DECAY_6581 (mode=0) or DECAY_8580 (mode=1).
REQ-030 The ttl counter SHALL be 20 bits and SHALL decrement on each ce_1m while nonzero.
REQ-031 On the ce_1m tick where ttl transitions 1 to 0, bus_value SHALL become 0x00.
REQ-032 A write on the same tick as expiry SHALL win: bus_value = data_in and ttl reloads.
REQ-033 Reads SHALL NOT alter bus_value or ttl.
REQ-034 A change of mode SHALL NOT reload a running ttl; the new lifetime SHALL apply from the next write.
REQ-035 Unused bits (PW_HI[7:4], FC_LO[7:3]) SHALL be discarded on write and SHALL NOT appear in bus-independent outputs.

Reset
REQ-036 While reset=1, every register output, data_out, bus_value and ttl SHALL be 0 on the next clk edge, regardless of ce_1m.
REQ-037 A write coincident with reset SHALL be ignored.
REQ-038 A reset asserted mid-decay SHALL clear bus_value immediately.

Structure
REQ-039 Package sid_pkg SHALL hold the register address constants (REG_FREQ_LO ... REG_ENV3), VOICE_STRIDE=7 and the decay defaults.
REQ-040 The 7-byte voice register set SHALL be one sub-module sid_voice_regs, instantiated 3 times with base offsets 0, 7 and 14.
REQ-041 No other sub-modules SHALL be used.

Verification
REQ-042 Write 0x34 to 0x00 and 0x12 to 0x01 -> freq[0]=0x1234 one clk after the second write; freq[1] and freq[2] stay 0.
REQ-043 Write 0xFF to 0x03 and 0xFF to 0x15 -> pw[0]=0xF00 and fc=0x007; read 0x03 returns 0xFF (bus value).
REQ-044 mode=0, write 0xAA to 0x18, then read 0x1D at ce tick 7423 and at tick 7424 -> 0xAA, then 0x00; Mode_Vol stays 0xAA.
REQ-045 mode=1, same sequence -> read at tick 7424 still 0xAA; read at tick 663552 returns 0x00.
REQ-046 osc3=0x5C, env3=0xC3, read 0x1B and 0x1C -> data_out 0x5C, then 0xC3; bus_value unchanged.
REQ-047 Write 0x0F to 0x18, then assert reset for 1 clk during decay -> Mode_Vol=0 and a read of 0x1F returns 0x00; a cs&&we pulse coincident with reset has no effect.
